// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video test-pattern path:
//   - mode_t       : pattern mode encoding (MODE_BARS/CHECK/GRAD/GRID)
//   - C_FULL/HALF/QUARTER : 8-bit channel intensities used by the patterns
//   - bar_rgb()    : the 8-colour bar table, 8 bits per channel {R,G,B}
//   - window_origin(): offset that centres a scaled source inside a raster
// -----------------------------------------------------------------------------
package video_pkg;

   typedef enum logic [1:0] {
      MODE_BARS  = 2'd0,
      MODE_CHECK = 2'd1,
      MODE_GRAD  = 2'd2,
      MODE_GRID  = 2'd3
   } mode_t;

   localparam logic [7:0] C_FULL    = 8'hFF;
   localparam logic [7:0] C_HALF    = 8'h80;
   localparam logic [7:0] C_QUARTER = 8'h40;

   // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   endfunction

   // Left/top margin that centres src*scale pixels inside 'active' pixels.
   function automatic int window_origin(input int active, input int src, input int scale);
      return (active - src * scale) / 2;
   endfunction

endpackage

// File: rtl/nes_testsrc_color.sv
// -----------------------------------------------------------------------------
// nes_testsrc_color
// Combinational colour generator for the test source, 8 bits per channel.
// Ports:
//   i_mode      : latched pattern mode
//   i_pat_x     : horizontal pattern coordinate (source column, possibly scrolled)
//   i_src_x_lsb : low 3 bits of the unscrolled source column (tile grid lines)
//   i_src_y     : source row
//   o_rgb       : {R,G,B}, 8 bits each
// -----------------------------------------------------------------------------
module nes_testsrc_color
   import video_pkg::*;
#(
   parameter int SRC_W = 256
) (
   input  mode_t       i_mode,
   input  logic [7:0]  i_pat_x,
   input  logic [2:0]  i_src_x_lsb,
   input  logic [7:0]  i_src_y,
   output logic [23:0] o_rgb
);

   localparam int BAR_COLS = SRC_W / 8;

   logic [7:0] w_bar_q;
   logic [2:0] w_bar_idx;

   // Pattern selection; a scrolled x beyond the last bar clamps to black.
   always_comb begin
      w_bar_q   = 8'(32'(i_pat_x) / BAR_COLS);
      w_bar_idx = (w_bar_q > 8'd7) ? 3'd7 : w_bar_q[2:0];
      o_rgb     = 24'h000000;
      case (i_mode)
         MODE_BARS: o_rgb = bar_rgb(w_bar_idx);
         MODE_CHECK: begin
            if (i_pat_x[3] ^ i_src_y[3]) o_rgb = {C_FULL, C_FULL, C_FULL};
            else                         o_rgb = 24'h000000;
         end
         MODE_GRAD: o_rgb = {i_pat_x, i_src_y, 8'h00};
         MODE_GRID: begin
            if ((i_src_x_lsb == 3'd0) || (i_src_y[2:0] == 3'd0))
               o_rgb = {C_HALF, C_HALF, C_HALF};
            else
               o_rgb = {16'h0000, C_QUARTER};
         end
         default: o_rgb = 24'h000000;
      endcase
   end

endmodule

// File: rtl/nes_testsrc.sv
// -----------------------------------------------------------------------------
// nes_testsrc
// Test-pattern source for the HDMI path, standing in for the NES PPU. Places
// a SRC_W x SRC_H image, scaled by SCALE, centred in the ACTIVE_W x ACTIVE_H
// raster; BORDER_RGB outside the window. Advanced by the encoder's
// rd/newline/newframe handshake (priority newframe > newline > rd).
// Optional macro PATTERN_ANIM_EN: 8-bit frame counter scrolls modes 0-2.
// Ports:
//   clk_25MHz, rst (sync, active-high)
//   i_mode      : pattern select, latched at newframe
//   i_rd        : current pixel consumed, step one pixel
//   i_newline   : next line starts
//   i_newframe  : next frame starts
//   o_pixel     : {R,G,B} of the current position, BITS_PER_COLOR each
//   o_src_x/y   : source coordinates of the current position (0 outside)
//   o_in_window : current position lies inside the scaled window
// All outputs are registered and change on the same edge as the position.
// -----------------------------------------------------------------------------
module nes_testsrc
   import video_pkg::*;
#(
   parameter int          BITS_PER_COLOR = 8,
   parameter int          ACTIVE_W       = 640,
   parameter int          ACTIVE_H       = 480,
   parameter int          SRC_W          = 256,
   parameter int          SRC_H          = 240,
   parameter int          SCALE          = 2,
   parameter logic [23:0] BORDER_RGB     = 24'h000000
) (
   input  logic                          clk_25MHz,
   input  logic                          rst,
   input  logic [1:0]                    i_mode,
   input  logic                          i_rd,
   input  logic                          i_newline,
   input  logic                          i_newframe,
   output logic [3*BITS_PER_COLOR-1:0]   o_pixel,
   output logic [7:0]                    o_src_x,
   output logic [7:0]                    o_src_y,
   output logic                          o_in_window
);

   localparam int BPC   = BITS_PER_COLOR;
   localparam int HX_W  = $clog2(ACTIVE_W);
   localparam int HY_W  = $clog2(ACTIVE_H);
   localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int X0    = window_origin(ACTIVE_W, SRC_W, SCALE);
   localparam int Y0    = window_origin(ACTIVE_H, SRC_H, SCALE);

   localparam logic [31:0]      X0_U    = 32'(X0);
   localparam logic [31:0]      X1_U    = 32'(X0 + SRC_W * SCALE);
   localparam logic [31:0]      Y0_U    = 32'(Y0);
   localparam logic [31:0]      Y1_U    = 32'(Y0 + SRC_H * SCALE);
   localparam logic [HX_W-1:0]  HX_MAX  = HX_W'(ACTIVE_W - 1);
   localparam logic [HY_W-1:0]  HY_MAX  = HY_W'(ACTIVE_H - 1);
   localparam logic [HX_W-1:0]  HX_X0   = HX_W'(X0);
   localparam logic [HY_W-1:0]  HY_Y0   = HY_W'(Y0);
   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SCALE - 1);

   // 8-bit channel to BPC bits: left-justified when wider, top bits when narrower.
   function automatic logic [BPC-1:0] map8(input logic [7:0] v);
      return BPC'({v, {BPC{1'b0}}} >> 8);
   endfunction

   function automatic logic [3*BPC-1:0] map_rgb(input logic [23:0] c);
      return {map8(c[23:16]), map8(c[15:8]), map8(c[7:0])};
   endfunction

   localparam logic [3*BPC-1:0] BORDER_PIX = map_rgb(BORDER_RGB);

   // Position and sub-counter state.
   logic [HX_W-1:0]  r_hx, w_hx_nxt;
   logic [HY_W-1:0]  r_hy, w_hy_nxt;
   logic [SUB_W-1:0] r_xsub, w_xsub_nxt;
   logic [SUB_W-1:0] r_ysub, w_ysub_nxt;
   logic [7:0]       r_sx, w_sx_nxt;
   logic [7:0]       r_sy, w_sy_nxt;
   mode_t            r_mode, w_mode_nxt;
   logic             w_x_step, w_y_step;
   logic             w_in_x_nxt, w_in_y_nxt, w_in_win_nxt;
   logic [7:0]       w_pat_x;
   logic [23:0]      w_rgb;
   logic [3*BPC-1:0] w_pixel_nxt;
`ifdef PATTERN_ANIM_EN
   logic [7:0]       r_frame, w_frame_nxt;
`endif

   // Handshake decode: next raster position and latched mode.
   always_comb begin
      w_hx_nxt   = r_hx;
      w_hy_nxt   = r_hy;
      w_mode_nxt = r_mode;
      w_x_step   = 1'b0;
      w_y_step   = 1'b0;
`ifdef PATTERN_ANIM_EN
      w_frame_nxt = r_frame;
`endif
      if (i_newframe) begin
         w_hx_nxt   = '0;
         w_hy_nxt   = '0;
         w_mode_nxt = mode_t'(i_mode);
`ifdef PATTERN_ANIM_EN
         w_frame_nxt = r_frame + 8'd1;
`endif
      end else if (i_newline) begin
         w_hx_nxt = '0;
         if (r_hy != HY_MAX) begin
            w_hy_nxt = r_hy + HY_W'(1);
            w_y_step = 1'b1;
         end else begin
            w_hy_nxt = r_hy;
         end
      end else if (i_rd) begin
         if (r_hx != HX_MAX) begin
            w_hx_nxt = r_hx + HX_W'(1);
            w_x_step = 1'b1;
         end else begin
            w_hx_nxt = r_hx;
         end
      end else begin
         w_hx_nxt = r_hx;
      end
   end

   // Source column: restart at the window edge, step every SCALE pixels,
   // hold when the position did not move (overrun saturation).
   always_comb begin
      w_in_x_nxt = (32'(w_hx_nxt) >= X0_U) && (32'(w_hx_nxt) < X1_U);
      w_sx_nxt   = r_sx;
      w_xsub_nxt = r_xsub;
      if (!w_in_x_nxt || (w_hx_nxt == HX_X0)) begin
         w_sx_nxt   = 8'd0;
         w_xsub_nxt = '0;
      end else if (w_x_step) begin
         if (r_xsub == SUB_MAX) begin
            w_xsub_nxt = '0;
            w_sx_nxt   = r_sx + 8'd1;
         end else begin
            w_xsub_nxt = r_xsub + SUB_W'(1);
         end
      end else begin
         w_sx_nxt   = r_sx;
      end
   end

   // Source row: same scheme, stepped by newline.
   always_comb begin
      w_in_y_nxt = (32'(w_hy_nxt) >= Y0_U) && (32'(w_hy_nxt) < Y1_U);
      w_sy_nxt   = r_sy;
      w_ysub_nxt = r_ysub;
      if (!w_in_y_nxt || (w_hy_nxt == HY_Y0)) begin
         w_sy_nxt   = 8'd0;
         w_ysub_nxt = '0;
      end else if (w_y_step) begin
         if (r_ysub == SUB_MAX) begin
            w_ysub_nxt = '0;
            w_sy_nxt   = r_sy + 8'd1;
         end else begin
            w_ysub_nxt = r_ysub + SUB_W'(1);
         end
      end else begin
         w_sy_nxt   = r_sy;
      end
   end

   // Horizontal pattern coordinate; the grid mode uses the raw column instead.
   always_comb begin
`ifdef PATTERN_ANIM_EN
      w_pat_x = w_sx_nxt + w_frame_nxt;
`else
      w_pat_x = w_sx_nxt;
`endif
   end

   nes_testsrc_color #(
      .SRC_W (SRC_W)
   ) u_color (
      .i_mode      (w_mode_nxt),
      .i_pat_x     (w_pat_x),
      .i_src_x_lsb (w_sx_nxt[2:0]),
      .i_src_y     (w_sy_nxt),
      .o_rgb       (w_rgb)
   );

   // Output selection for the next position: pattern inside, border outside.
   always_comb begin
      w_in_win_nxt = w_in_x_nxt && w_in_y_nxt;
      if (w_in_win_nxt) w_pixel_nxt = map_rgb(w_rgb);
      else              w_pixel_nxt = BORDER_PIX;
   end

   // State and output registers, all updated on the same edge.
   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         r_hx        <= '0;
         r_hy        <= '0;
         r_xsub      <= '0;
         r_ysub      <= '0;
         r_sx        <= 8'd0;
         r_sy        <= 8'd0;
         r_mode      <= MODE_BARS;
         o_pixel     <= BORDER_PIX;
         o_src_x     <= 8'd0;
         o_src_y     <= 8'd0;
         o_in_window <= 1'b0;
`ifdef PATTERN_ANIM_EN
         r_frame     <= 8'd0;
`endif
      end else begin
         r_hx        <= w_hx_nxt;
         r_hy        <= w_hy_nxt;
         r_xsub      <= w_xsub_nxt;
         r_ysub      <= w_ysub_nxt;
         r_sx        <= w_sx_nxt;
         r_sy        <= w_sy_nxt;
         r_mode      <= w_mode_nxt;
         o_pixel     <= w_pixel_nxt;
         o_src_x     <= w_in_win_nxt ? w_sx_nxt : 8'd0;
         o_src_y     <= w_in_win_nxt ? w_sy_nxt : 8'd0;
         o_in_window <= w_in_win_nxt;
`ifdef PATTERN_ANIM_EN
         r_frame     <= w_frame_nxt;
`endif
      end
   end

endmodule

// File: doc/nes_testsrc.md
# nes_testsrc

Parametrised, multi-mode test-pattern source for the HDMI path. It places a SRC_W×SRC_H source image, integer-scaled by SCALE, centred inside the ACTIVE_W×ACTIVE_H encoder raster, with a border colour outside the window. It is driven by the HDMI encoder's pixel-request handshake (rd/newline/newframe). It stands in for the NES PPU until the PPU exists, and exports the same source coordinates the PPU framebuffer reader will use.

## Interface
- BITS_PER_COLOR, 8: bits per colour channel; legal range 4..10.
- ACTIVE_W, 640: encoder active pixels per line.
- ACTIVE_H, 480: encoder active lines per frame.
- SRC_W, 256: source width, multiple of 8.
- SRC_H, 240: source height, multiple of 8.
- SCALE, 2: integer scale factor; SRC_W·SCALE ≤ ACTIVE_W and SRC_H·SCALE ≤ ACTIVE_H.
- BORDER_RGB, 24'h000000: border colour, 8 bits per channel, mapped to BITS_PER_COLOR.
- clk_25MHz  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- i_mode  in  2  pattern select; sampled only at frame start.
- i_rd  in  1  current pixel consumed; advance one pixel.
- i_newline  in  1  next line starts.
- i_newframe  in  1  next frame starts.
- o_pixel  out  3·BITS_PER_COLOR  colour of the current position, {R,G,B}.
- o_src_x  out  8  source column of the current position.
- o_src_y  out  8  source row of the current position.
- o_in_window  out  1  current position lies inside the scaled window.

## Operation
- Position registers: hx (0..ACTIVE_W-1) and hy (0..ACTIVE_H-1).
- Window origin:
  - X0 = (ACTIVE_W − SRC_W·SCALE)/2, which is 64 at defaults.
  - Y0 = (ACTIVE_H − SRC_H·SCALE)/2, which is 0 at defaults.
- Event priority: i_newframe > i_newline > i_rd.
  - newframe: hx=0, hy=0, x/y sub-counters=0, mode latched from i_mode.
  - newline: hx=0; hy+1, saturating at ACTIVE_H-1; y sub-counter steps.
  - rd: hx+1, saturating at ACTIVE_W-1.
- Source coordinates:
  - src_x = (hx−X0)/SCALE and src_y = (hy−Y0)/SCALE.
  - Implemented with sub-counters modulo SCALE, not dividers.
  - Outside the window, src_x/src_y hold 0.
- Modes, from the latched mode value (c = BITS_PER_COLOR all-ones):
  - 0, colour bars: 8 bars of SRC_W/8 columns each, in order white, yellow, cyan, green, magenta, red, blue, black.
  - 1, checker: white if src_x[3]^src_y[3], else black.
  - 2, gradient: R=src_x, G=src_y, B=0.
  - 3, tile grid: grey (half-scale) where src_x[2:0]==0 or src_y[2:0]==0, else dark blue (B = quarter-scale).
- 8-bit to BITS_PER_COLOR mapping:
  - BITS_PER_COLOR ≥ 8: value left-justified, low bits zero.
  - BITS_PER_COLOR < 8: the top BITS_PER_COLOR bits are used.
- Outside the window: o_pixel = BORDER_RGB and o_in_window = 0.
- Changes on i_mode mid-frame have no effect until the next newframe.

## Timing
- All outputs are registered. They always describe the current position, and they update on the same edge as the position registers. This gives zero bubbles under back-to-back i_rd.
- Reset values:
  - hx=hy=0, sub-counters=0, mode=0, frame counter=0.
  - o_pixel=BORDER_RGB, o_src_x=0, o_src_y=0, o_in_window=0.
  - These hold for defaults, where X0 > 0.
- Reset mid-line discards all position state. The first newframe after reset resynchronises.
- Simultaneous newframe+newline+rd: only the newframe action occurs.
- Overrun (more than ACTIVE_W rd pulses in a line): hx holds at ACTIVE_W-1 and o_pixel shows the border until the next newline.

## Configuration
- PATTERN_ANIM_EN defined:
  - An 8-bit frame counter increments on each newframe.
  - Modes 0–2 use (src_x + frame) mod 256 in place of src_x, giving horizontal scroll.
  - o_src_x is not offset.
- PATTERN_ANIM_EN undefined: no frame counter; patterns are static.

## Structure
- Shared package video_pkg holds:
  - the mode encoding constants (MODE_BARS, MODE_CHECK, MODE_GRAD, MODE_GRID);
  - the 8-colour bar table;
  - the function computing X0/Y0.
- Sub-module nes_testsrc_color: combinational colour generation from mode, src_x and src_y. The parent owns all counters and output registers.

## Test plan
- Reset, release rst → o_pixel=000000, o_in_window=0, o_src_x=0, o_src_y=0.
- Mode 0, newframe, then 64 rd → o_in_window=1, src_x=0, o_pixel=FFFFFF. After 64 more rd (src_x=32) → FFFF00.
- Scaling: hx=64,65 → src_x=0; hx=66 → src_x=1; hx=575 → src_x=255; hx=576 → border, in_window=0.
- Mode 2, newframe, 10 newlines, 264 rd → src_y=5, src_x=100, o_pixel=64_05_00.
- Back-to-back: 700 consecutive rd → hx saturates at 639 with border. newline+rd in the same cycle → hx=0. i_mode changed mid-frame → no effect until newframe.
- With PATTERN_ANIM_EN: mode 0, 32 newframes, then 64 rd → o_pixel=FFFF00 at src_x=0. Without the macro → FFFFFF.
